// File: rtl/result_collector.sv
// Collects one job of signed result words, then streams them out over a valid/ready port.
// Optional RESULT_CHECKSUM_EN macro adds a wrapping checksum of captured words.
module result_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 9,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_done,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic [CNT_W-1:0]         count,
  output logic                     overflow,
  output logic                     drain_done,
  output logic [DATA_W-1:0]        checksum,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic signed [DATA_W-1:0]   r_mem [DEPTH];
  logic [CNT_W-1:0]           r_count;
  logic [CNT_W-1:0]           r_rd_ptr;
  logic                       r_overflow;
  logic                       w_capture;
  logic [CNT_W-1:0]           w_wr_addr;
  logic                       w_last;
  logic                       w_xfer;

  // Handshake: a word moves when out_valid && out_ready on a rising edge;
  // while out_ready is low, out_valid/out_data/out_last hold unchanged.
  assign w_last    = (r_state == DRAIN) && (r_rd_ptr == r_count - CNT_W'(1));
  assign w_xfer    = (r_state == DRAIN) && out_ready;
  assign w_capture = in_valid && ((r_state == IDLE) ||
                     ((r_state == CAPTURE) && (r_count < CNT_W'(DEPTH))));
  assign w_wr_addr = (r_state == IDLE) ? '0 : r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CAPTURE;
      CAPTURE: if (in_done) w_next = DRAIN;
      DRAIN:   if (w_xfer && w_last) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = 1'b0;
    out_last   = 1'b0;
    drain_done = 1'b0;
    case (r_state)
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_last;
      end
      FINISH:  drain_done = 1'b1;
      default: ;
    endcase
  end

  // Storage carries no reset; only words below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_capture) r_mem[w_wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_count    <= CNT_W'(1);
            r_overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_capture)     r_count    <= r_count + CNT_W'(1);
          else if (in_valid) r_overflow <= 1'b1;
        end
        DRAIN: begin
          if (in_valid) r_overflow <= 1'b1;
          if (w_xfer)   r_rd_ptr   <= r_rd_ptr + CNT_W'(1);
        end
        FINISH: begin
          if (in_valid) r_overflow <= 1'b1;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // The first word of a job restarts the sum rather than adding to the old one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_checksum <= '0;
    end else if (w_capture) begin
      if (r_state == IDLE) r_checksum <= in_data;
      else                 r_checksum <= r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule
